// File: rtl/ddrphy_cke_pkg.sv
// Shared types and constants for the DDR3 PHY CKE lane controller.
// Holds the adjust FSM state encoding and lane reset levels.
package ddrphy_cke_pkg;

    localparam int TAP_W = 8;
    localparam int CNT_W = 4;

    localparam logic       CKE_RST = 1'b0;
    localparam logic [3:0] OE_RST  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } adj_state_e;

    // True when one more tap in direction dir would leave 0..max.
    function automatic logic tap_at_edge(
        input logic [TAP_W-1:0] tap,
        input logic             dir,
        input logic [TAP_W-1:0] max
    );
        return dir ? (tap == max) : (tap == '0);
    endfunction

endpackage

// File: rtl/ddrphy_dly_step_fsm.sv
// Delay-line adjust sequencer: direction setup, spaced MOVE pulses,
// LOAD restore, out-of-range abort and tap tracking.
module ddrphy_dly_step_fsm
    import ddrphy_cke_pkg::*;
#(
    parameter int STEP_GAP    = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int INIT_TAP    = 1,
    parameter int DLY_MAX     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adj_valid,
    output logic             adj_ready,
    input  logic             adj_dir,
    input  logic [TAP_W-1:0] adj_steps,
    input  logic             adj_load,
    output logic             adj_done,
    output logic             adj_oor,
    output logic [TAP_W-1:0] tap_count,
    output logic             dly_move,
    output logic             dly_dir,
    output logic             dly_load,
    input  logic             dly_oor
);

    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(DLY_MAX);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(STEP_GAP - 1);
    localparam logic [CNT_W-1:0] LOAD_LD  = CNT_W'(LOAD_CYCLES - 1);

    adj_state_e       state_q;
    adj_state_e       state_d;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             oor_q;
    logic             rdy_en_q;
    logic             ready;
    logic             accept;
    logic             at_edge;

    assign accept  = adj_valid & ready;
    assign at_edge = tap_at_edge(tap_q, dir_q, TAP_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (adj_load) begin
                        state_d = ST_LOAD;
                    end else if (adj_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_LOAD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_SETUP: begin
                state_d = at_edge ? ST_DONE : ST_MOVE;
            end
            ST_MOVE: begin
                state_d = (rem_q == TAP_W'(1)) ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                if (dly_oor) begin
                    state_d = ST_DONE;
                end else if (cnt_q == '0) begin
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane strobes and handshake decoded from the current state.
    always_comb begin
        ready    = rdy_en_q & (state_q == ST_IDLE);
        dly_move = (state_q == ST_MOVE);
        dly_load = (state_q == ST_LOAD);
        adj_done = (state_q == ST_DONE);
    end

    // Tap tracking, step/gap/load counters, direction and sticky abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q    <= TAP_INIT;
            rem_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            oor_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        oor_q <= 1'b0;
                        if (adj_load) begin
                            cnt_q <= LOAD_LD;
                        end else if (adj_steps != '0) begin
                            dir_q <= adj_dir;
                            rem_q <= adj_steps;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == '0) begin
                        tap_q <= TAP_INIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (at_edge) begin
                        oor_q <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    tap_q <= dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
                    rem_q <= rem_q - 1'b1;
                    cnt_q <= GAP_LD;
                end
                ST_GAP: begin
                    if (dly_oor) begin
                        oor_q <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign adj_ready = ready;
    assign adj_oor   = oor_q;
    assign tap_count = tap_q;
    assign dly_dir   = dir_q;

endmodule

// File: rtl/ddrphy_cke_lane_ctrl.sv
// Fabric-side CKE lane controller: CKE hold/expansion to TX/OE words
// plus the delay-line adjust sequencer for the CKE I/O lane.
module ddrphy_cke_lane_ctrl
    import ddrphy_cke_pkg::*;
#(
    parameter int TCKE_MIN    = 4,
    parameter int STEP_GAP    = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int INIT_TAP    = 1,
    parameter int DLY_MAX     = 255
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             CKE_REQ,
    input  logic             ADJ_VALID,
    output logic             ADJ_READY,
    input  logic             ADJ_DIR,
    input  logic [TAP_W-1:0] ADJ_STEPS,
    input  logic             ADJ_LOAD,
    output logic             ADJ_DONE,
    output logic             ADJ_OOR,
    output logic [TAP_W-1:0] TAP_COUNT,
    output logic [3:0]       TX_DATA_0,
    output logic [3:0]       OE_DATA_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0,
    output logic             ODT_EN_0
);

    localparam int HOLD_W = (TCKE_MIN > 2) ? $clog2(TCKE_MIN) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(TCKE_MIN - 1);

    logic              cke_q;
    logic [HOLD_W-1:0] hold_q;
    logic [3:0]        tx_q;
    logic [3:0]        oe_q;

    // CKE level with minimum hold: new requests only sampled once hold expires.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            cke_q  <= CKE_RST;
            hold_q <= '0;
        end else if (hold_q == '0) begin
            cke_q <= CKE_REQ;
            if (CKE_REQ != cke_q) begin
                hold_q <= HOLD_LD;
            end
        end else begin
            hold_q <= hold_q - 1'b1;
        end
    end

    // Expand the CKE level into the per-FAB_CLK serialiser words.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            tx_q <= {4{CKE_RST}};
            oe_q <= OE_RST;
        end else begin
            tx_q <= {4{cke_q}};
            oe_q <= OE_RST;
        end
    end

    assign TX_DATA_0 = tx_q;
    assign OE_DATA_0 = oe_q;
    assign ODT_EN_0  = 1'b0;

    ddrphy_dly_step_fsm #(
        .STEP_GAP    (STEP_GAP),
        .LOAD_CYCLES (LOAD_CYCLES),
        .INIT_TAP    (INIT_TAP),
        .DLY_MAX     (DLY_MAX)
    ) u_step (
        .clk       (FAB_CLK),
        .rst_n     (ARST_N),
        .adj_valid (ADJ_VALID),
        .adj_ready (ADJ_READY),
        .adj_dir   (ADJ_DIR),
        .adj_steps (ADJ_STEPS),
        .adj_load  (ADJ_LOAD),
        .adj_done  (ADJ_DONE),
        .adj_oor   (ADJ_OOR),
        .tap_count (TAP_COUNT),
        .dly_move  (DELAY_LINE_MOVE_0),
        .dly_dir   (DELAY_LINE_DIRECTION_0),
        .dly_load  (DELAY_LINE_LOAD_0),
        .dly_oor   (DELAY_LINE_OUT_OF_RANGE_0)
    );

endmodule

// File: tb/tb_ddrphy_cke_lane_ctrl.sv
// Directed bench for the CKE lane controller: reset, CKE hold,
// stepped moves, range aborts, LOAD and mid-request reset.
module tb_ddrphy_cke_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cke_req = 1'b0;
    logic       adj_valid = 1'b0;
    logic       adj_ready;
    logic       adj_dir = 1'b0;
    logic [7:0] adj_steps = '0;
    logic       adj_load = 1'b0;
    logic       adj_done;
    logic       adj_oor;
    logic [7:0] tap;
    logic [3:0] tx;
    logic [3:0] oe;
    logic       mv;
    logic       ddir;
    logic       ld;
    logic       oor_in = 1'b0;
    logic       odt;

    int n_run = 0;
    int n_fail = 0;

    int mv_at[16];
    int n_mv;
    int n_done;
    int n_ld;
    logic dir_pre;

    always #5 clk = ~clk;

    ddrphy_cke_lane_ctrl dut (
        .FAB_CLK                   (clk),
        .ARST_N                    (rst_n),
        .CKE_REQ                   (cke_req),
        .ADJ_VALID                 (adj_valid),
        .ADJ_READY                 (adj_ready),
        .ADJ_DIR                   (adj_dir),
        .ADJ_STEPS                 (adj_steps),
        .ADJ_LOAD                  (adj_load),
        .ADJ_DONE                  (adj_done),
        .ADJ_OOR                   (adj_oor),
        .TAP_COUNT                 (tap),
        .TX_DATA_0                 (tx),
        .OE_DATA_0                 (oe),
        .DELAY_LINE_MOVE_0         (mv),
        .DELAY_LINE_DIRECTION_0    (ddir),
        .DELAY_LINE_LOAD_0         (ld),
        .DELAY_LINE_OUT_OF_RANGE_0 (oor_in),
        .ODT_EN_0                  (odt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic dir, input logic [7:0] steps,
                         input logic load);
        chk("ready_before_issue", 32'(adj_ready), 1);
        adj_valid = 1'b1;
        adj_dir   = dir;
        adj_steps = steps;
        adj_load  = load;
        tick();
        adj_valid = 1'b0;
        adj_load  = 1'b0;
        adj_steps = '0;
    endtask

    // Follows one request until ADJ_DONE; c=0 is the cycle after accept.
    task automatic watch(input int oor_after, input int budget);
        logic prev_dir;
        bit   raised;
        prev_dir = ddir;
        raised   = 0;
        n_mv     = 0;
        n_done   = 0;
        n_ld     = 0;
        dir_pre  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (mv) begin
                if (n_mv == 0) dir_pre = prev_dir;
                if (n_mv < 16) mv_at[n_mv] = c;
                n_mv++;
            end
            if (ld) n_ld++;
            if (adj_done) n_done++;
            if (oor_after > 0 && !raised && n_mv == oor_after && !mv) begin
                oor_in = 1'b1;
                raised = 1;
            end
            prev_dir = ddir;
            if (adj_done) begin
                oor_in = 1'b0;
                tick();
                break;
            end
            tick();
        end
        oor_in = 1'b0;
    endtask

    initial begin
        // Asynchronous reset
        #3 rst_n = 1'b0;
        #2;
        chk("rst_ready", 32'(adj_ready), 0);
        chk("rst_tx", 32'(tx), 32'h0);
        chk("rst_oe", 32'(oe), 32'hf);
        chk("rst_tap", 32'(tap), 1);
        chk("rst_strobes", {29'd0, mv, ld, adj_done}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(adj_ready), 1);
        chk("post_rst_tx", 32'(tx), 32'h0);
        chk("post_rst_oe", 32'(oe), 32'hf);
        chk("post_rst_tap", 32'(tap), 1);
        chk("post_rst_oor", 32'(adj_oor), 0);
        chk("odt", 32'(odt), 0);

        // CKE 0->1 at t, 1->0 at t+1: high t+1..t+4, low from t+5
        cke_req = 1'b1;
        tick();
        cke_req = 1'b0;
        chk("cke_t0", 32'(tx), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("cke_hold_%0d", i), 32'(tx), 32'hf);
        end
        tick();
        chk("cke_low_t5", 32'(tx), 32'h0);
        chk("cke_oe", 32'(oe), 32'hf);

        // Up 3 steps from tap 1
        issue(1'b1, 8'd3, 1'b0);
        watch(0, 60);
        chk("up3_moves", n_mv, 3);
        chk("up3_first", mv_at[0], 1);
        chk("up3_gap1", mv_at[1] - mv_at[0], 6);
        chk("up3_gap2", mv_at[2] - mv_at[1], 6);
        chk("up3_dir_lead", 32'(dir_pre), 1);
        chk("up3_done", n_done, 1);
        chk("up3_tap", 32'(tap), 4);
        chk("up3_oor", 32'(adj_oor), 0);
        chk("up3_ready", 32'(adj_ready), 1);

        // LOAD back to tap 1
        issue(1'b0, 8'd0, 1'b1);
        watch(0, 20);
        chk("load1_cycles", n_ld, 2);
        chk("load1_tap", 32'(tap), 1);
        chk("load1_done", n_done, 1);

        // Down 5 from tap 1: one move to 0 then abort
        issue(1'b0, 8'd5, 1'b0);
        watch(0, 60);
        chk("dn5_moves", n_mv, 1);
        chk("dn5_done", n_done, 1);
        chk("dn5_oor", 32'(adj_oor), 1);
        chk("dn5_tap", 32'(tap), 0);
        chk("dn5_dir", 32'(ddir), 0);

        // Up 10 from tap 0, lane out-of-range in gap after 2nd move
        issue(1'b1, 8'd10, 1'b0);
        chk("up10_oor_clr", 32'(adj_oor), 0);
        watch(2, 80);
        chk("up10_moves", n_mv, 2);
        chk("up10_done", n_done, 1);
        chk("up10_oor", 32'(adj_oor), 1);
        chk("up10_tap", 32'(tap), 2);

        // LOAD after abort
        issue(1'b0, 8'd0, 1'b1);
        chk("load2_oor_clr", 32'(adj_oor), 0);
        watch(0, 20);
        chk("load2_cycles", n_ld, 2);
        chk("load2_tap", 32'(tap), 1);
        chk("load2_oor", 32'(adj_oor), 0);

        // Zero-step request completes without moving
        issue(1'b1, 8'd0, 1'b0);
        watch(0, 10);
        chk("zero_moves", n_mv, 0);
        chk("zero_done", n_done, 1);
        chk("zero_tap", 32'(tap), 1);

        // Reset in GAP of a 5-step request with CKE high
        cke_req = 1'b1;
        issue(1'b1, 8'd5, 1'b0);
        begin
            int k;
            k = 0;
            while (!mv && k < 20) begin
                tick();
                k++;
            end
            chk("rst5_move_seen", 32'(mv), 1);
        end
        tick();
        tick();
        chk("rst5_tx_pre", 32'(tx), 32'hf);
        chk("rst5_tap_pre", 32'(tap), 2);
        rst_n = 1'b0;
        #1;
        chk("rst5_strobes", {29'd0, mv, ld, adj_done}, 0);
        chk("rst5_tx", 32'(tx), 32'h0);
        chk("rst5_oe", 32'(oe), 32'hf);
        chk("rst5_tap", 32'(tap), 1);
        chk("rst5_ready", 32'(adj_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        cke_req = 1'b0;
        tick();
        chk("rst5_idle", 32'(adj_ready), 1);
        chk("rst5_tap_post", 32'(tap), 1);
        chk("rst5_move_post", 32'(mv), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ddrphy_cke_lane_ctrl.md
Name: ddrphy_cke_lane_ctrl

Overview:
Fabric-side controller directly upstream of the CKE I/O lane of the DDR3 PHY, clocked on FAB_CLK.
- Expands a single-bit CKE request into the 4-bit-per-FAB_CLK TX/OE data words the lane serialises.
- Enforces minimum CKE hold time.
- Sequences the lane's dynamic output delay line: direction setup, single MOVE pulses with spacing, LOAD, out-of-range abort.
- Exposes a valid/ready request interface to the PHY training logic.

Parameters:
TCKE_MIN, 4, minimum FAB_CLK cycles CKE output holds a new level before another change is accepted
STEP_GAP, 4, idle FAB_CLK cycles between consecutive DELAY_LINE_MOVE pulses (1..15)
LOAD_CYCLES, 2, FAB_CLK cycles DELAY_LINE_LOAD is held high (1..7)
INIT_TAP, 1, tap value restored by LOAD; reset value of TAP_COUNT
DLY_MAX, 255, highest legal tap

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
ARST_N  in  1  asynchronous active-low reset
CKE_REQ  in  1  requested CKE level
ADJ_VALID  in  1  delay adjust request valid
ADJ_READY  out  1  controller idle, request accepted when VALID&READY
ADJ_DIR  in  1  1 = increment taps, 0 = decrement
ADJ_STEPS  in  8  number of single-tap moves
ADJ_LOAD  in  1  1 = reload delay line to INIT_TAP (ADJ_DIR/ADJ_STEPS ignored)
ADJ_DONE  out  1  one-cycle pulse at end of request
ADJ_OOR  out  1  sticky: last request aborted on out-of-range
TAP_COUNT  out  8  tracked current tap
TX_DATA_0  out  4  to lane TX data
OE_DATA_0  out  4  to lane OE data
DELAY_LINE_MOVE_0  out  1  to lane
DELAY_LINE_DIRECTION_0  out  1  to lane
DELAY_LINE_LOAD_0  out  1  to lane
DELAY_LINE_OUT_OF_RANGE_0  in  1  from lane
ODT_EN_0  out  1  to lane; constant 0 (CKE has no termination)

Behaviour:
- Reset values:
  - TX_DATA_0 = 4'b0000, so CKE is held low.
  - OE_DATA_0 = 4'b1111, so the pad is driven throughout.
  - MOVE, LOAD, DIRECTION = 0; ADJ_DONE = 0; ADJ_OOR = 0.
  - ADJ_READY = 0 while ARST_N is low, 1 from the first clock after release.
  - TAP_COUNT = INIT_TAP; FSM in IDLE.
- Reset asserted mid-operation: all of the above apply immediately and asynchronously; no partial MOVE/LOAD pulse completes.
- CKE path:
  - Registered, latency 1: TX_DATA_0 <= {4{cke_q}}.
  - cke_q takes CKE_REQ only when the hold counter is 0.
  - On each change of cke_q, the hold counter loads TCKE_MIN-1 and counts down; CKE_REQ toggles during hold are ignored.
  - When the hold counter reaches 0, the current CKE_REQ is sampled.
- OE_DATA_0 stays 4'b1111 after reset.
- Adjust FSM states: IDLE, LOAD, SETUP, MOVE, GAP, DONE.
  - IDLE: ADJ_READY=1. On accept:
    - ADJ_OOR clears.
    - ADJ_LOAD=1 -> LOAD.
    - Else ADJ_STEPS=0 -> DONE.
    - Else latch DIRECTION=ADJ_DIR, remaining=ADJ_STEPS -> SETUP.
    - ADJ_READY=0 in all other states.
  - LOAD: DELAY_LINE_LOAD_0=1 for LOAD_CYCLES cycles, then TAP_COUNT<=INIT_TAP -> DONE.
  - SETUP: one cycle with DIRECTION stable and MOVE=0, so direction leads MOVE by >=1 cycle.
    - If the move would leave 0..DLY_MAX (TAP_COUNT=DLY_MAX with dir=1, or 0 with dir=0): ADJ_OOR<=1 -> DONE, no MOVE issued.
    - Else -> MOVE.
  - MOVE: DELAY_LINE_MOVE_0=1 for exactly one cycle; TAP_COUNT +/-1; remaining-1. -> GAP if remaining>0 after decrement, else DONE.
  - GAP: STEP_GAP cycles with MOVE=0.
    - DELAY_LINE_OUT_OF_RANGE_0 sampled high in any GAP cycle: ADJ_OOR<=1 -> DONE immediately.
    - Else at end of gap -> SETUP.
  - DONE: ADJ_DONE=1 for one cycle -> IDLE. DIRECTION keeps its last value.
- Simultaneous events:
  - ADJ_VALID during a non-IDLE state is not accepted; the requester holds it.
  - CKE path and adjust FSM are fully independent; a CKE change during MOVE is legal.

Decomposition:
- Package ddrphy_cke_pkg: adjust-state enum, TAP_W=8, CKE reset level (0), OE reset word (4'b1111).
- Sub-module ddrphy_dly_step_fsm holds the adjust FSM, TAP_COUNT and gap/load counters.
- Top instantiates it beside the CKE hold logic.

Test Plan:
- Reset release, CKE_REQ=0 -> TX_DATA_0=0000, OE_DATA_0=1111, TAP_COUNT=1, ADJ_READY=1 on the first post-reset clock.
- CKE_REQ 0->1 at t, 1->0 at t+1, TCKE_MIN=4 -> TX_DATA_0=1111 from t+1 through t+4, 0000 from t+5.
- ADJ_DIR=1, ADJ_STEPS=3, STEP_GAP=4 -> three 1-cycle MOVE pulses, DIRECTION=1 >=1 cycle before the first, pulses 6 cycles apart (SETUP+MOVE+4 GAP), TAP_COUNT=4, one ADJ_DONE, ADJ_OOR=0.
- TAP_COUNT=1, ADJ_DIR=0, ADJ_STEPS=5 -> one MOVE (tap 0), then abort in SETUP with no further MOVE, ADJ_OOR=1, ADJ_DONE pulse, TAP_COUNT=0.
- DELAY_LINE_OUT_OF_RANGE_0 raised in the GAP after the 2nd of 10 moves -> no 3rd MOVE, ADJ_OOR=1, ADJ_DONE; a subsequent ADJ_LOAD request -> LOAD high 2 cycles, TAP_COUNT=1, ADJ_OOR cleared.
- ARST_N asserted during GAP of a 5-step request -> MOVE/LOAD/ADJ_DONE=0, TX_DATA_0=0000 and OE_DATA_0=1111 immediately, TAP_COUNT=1, FSM IDLE after release.
